// File: rtl/reg_file_sb.sv
// Parametrised register file with two mux-based read ports, one write port,
// optional hardwired zero register, write-to-read bypass and a busy scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wrDrop;
    logic              rsvDrop;
    logic              wrLive;
    logic              fwd1;
    logic              fwd2;

    // Register 0 swallows writes and reservations when it is hardwired to zero.
    assign wrDrop  = (ZERO_REG != 0) && (wr_addr == '0);
    assign rsvDrop = (ZERO_REG != 0) && (rsv_addr == '0);
    assign wrLive  = wr_en && !wrDrop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrLive) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Set beats clear: a reservation in the same cycle as the retiring write
    // belongs to a newer producer of the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en && !rsvDrop) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign fwd1 = (BYPASS != 0) && wrLive && (wr_addr == rd_addr1);
    assign fwd2 = (BYPASS != 0) && wrLive && (wr_addr == rd_addr2);

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
        if (fwd1) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
        if (fwd2) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and random checks of reg_file_sb across bypass / zero-register variants.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;

    logic [15:0] aData1, aData2, bData1, bData2, zData1, zData2;
    logic        aBusy1, aBusy2, bBusy1, bBusy2, zBusy1, zBusy2;
    logic [15:0] aBusyVec, bBusyVec, zBusyVec;

    int checks = 0;
    int errors = 0;

    logic [15:0] mReg  [16];
    logic [15:0] mBusy;
    logic [15:0] zReg  [16];
    logic [15:0] zBusy;

    // Three variants share one set of inputs: A bypass, B no bypass, Z zero register.
    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dutA (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(aData1), .rd_data2(aData2), .rd_busy1(aBusy1), .rd_busy2(aBusy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(aBusyVec));

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(bData1), .rd_data2(bData2), .rd_busy1(bBusy1), .rd_busy2(bBusy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bBusyVec));

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dutZ (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(zData1), .rd_data2(zData2), .rd_busy1(zBusy1), .rd_busy2(zBusy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(zBusyVec));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; setIdle(); rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (aData1 !== 16'h0) begin errors++; $display("[TB] FAIL reset_init_data got %h want 0000", aData1); end
        checks++; if (aBusyVec !== 16'h0) begin errors++; $display("[TB] FAIL reset_init_busy got %h want 0000", aBusyVec); end
        // Load reg5 and mark it busy, then pull reset in the middle of a cycle.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rsv_en = 1'b1; rsv_addr = 4'd5;
        tick();
        setIdle(); rd_addr1 = 4'd5;
        #1;
        checks++; if (aData1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL reset_preload got %h want beef", aData1); end
        checks++; if (aBusyVec !== 16'h0020) begin errors++; $display("[TB] FAIL reset_prebusy got %h want 0020", aBusyVec); end
        #2 rst = 1'b1;
        #1;
        checks++; if (aData1 !== 16'h0) begin errors++; $display("[TB] FAIL reset_async_data got %h want 0000", aData1); end
        checks++; if (aBusyVec !== 16'h0) begin errors++; $display("[TB] FAIL reset_async_busy got %h want 0000", aBusyVec); end
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rsv_en = 1'b1; rsv_addr = 4'd5;
        tick();
        setIdle();
        #1;
        checks++; if (aData1 !== 16'h0 || bData1 !== 16'h0 || zData1 !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_held_data got %h %h %h want 0000", aData1, bData1, zData1); end
        checks++; if (aBusyVec !== 16'h0 || zBusyVec !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_held_busy got %h %h want 0000", aBusyVec, zBusyVec); end
        rst = 1'b0;
        tick();
        checks++; if (aData1 !== 16'h0 || aBusyVec !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_release got %h %h want 0000 0000", aData1, aBusyVec); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
        tick();
        wr_addr = 4'd12; wr_data = 16'hA5A5;
        tick();
        setIdle(); rd_addr1 = 4'd3; rd_addr2 = 4'd12;
        #1;
        checks++; if (aData1 !== 16'h1234) begin errors++; $display("[TB] FAIL wr_rd_port1 got %h want 1234", aData1); end
        checks++; if (aData2 !== 16'hA5A5) begin errors++; $display("[TB] FAIL wr_rd_port2 got %h want a5a5", aData2); end
        rd_addr1 = 4'd12;
        #1;
        checks++; if (aData1 !== 16'hA5A5 || aData2 !== 16'hA5A5) begin
            errors++; $display("[TB] FAIL wr_rd_same got %h %h want a5a5 a5a5", aData1, aData2); end
        checks++; if (bData2 !== 16'hA5A5 || zData1 !== 16'hA5A5) begin
            errors++; $display("[TB] FAIL wr_rd_variants got %h %h want a5a5 a5a5", bData2, zData1); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0001;
        tick();
        wr_data = 16'h00FF; rd_addr1 = 4'd7;
        #1;
        checks++; if (aData1 !== 16'h00FF) begin errors++; $display("[TB] FAIL bypass_on got %h want 00ff", aData1); end
        checks++; if (bData1 !== 16'h0001) begin errors++; $display("[TB] FAIL bypass_off_old got %h want 0001", bData1); end
        tick();
        setIdle();
        #1;
        checks++; if (bData1 !== 16'h00FF) begin errors++; $display("[TB] FAIL bypass_off_new got %h want 00ff", bData1); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr1 = 4'd0;
        #1;
        checks++; if (zData1 !== 16'h0) begin errors++; $display("[TB] FAIL zero_same_cycle got %h want 0000", zData1); end
        tick();
        setIdle();
        #1;
        checks++; if (zData1 !== 16'h0 || zBusyVec[0] !== 1'b0 || zBusy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_reg_on got %h %b %b want 0000 0 0", zData1, zBusyVec[0], zBusy1); end
        checks++; if (aData1 !== 16'hFFFF || aBusyVec[0] !== 1'b1 || aBusy1 !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_reg_off got %h %b %b want ffff 1 1", aData1, aBusyVec[0], aBusy1); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 4'd9;
        #1;
        checks++; if (aBusyVec[9] !== 1'b0) begin errors++; $display("[TB] FAIL sb_rsv_early got %b want 0", aBusyVec[9]); end
        tick();
        setIdle(); rd_addr1 = 4'd9; rd_addr2 = 4'd9;
        #1;
        checks++; if (aBusyVec[9] !== 1'b1 || aBusy1 !== 1'b1 || aBusy2 !== 1'b1) begin
            errors++; $display("[TB] FAIL sb_reserved got %b %b %b want 1 1 1", aBusyVec[9], aBusy1, aBusy2); end
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909;
        #1;
        checks++; if (aBusy1 !== 1'b0 || aData1 !== 16'h0909) begin
            errors++; $display("[TB] FAIL sb_bypass got %b %h want 0 0909", aBusy1, aData1); end
        checks++; if (bBusy1 !== 1'b1) begin errors++; $display("[TB] FAIL sb_nobypass got %b want 1", bBusy1); end
        tick();
        setIdle();
        #1;
        checks++; if (aBusyVec[9] !== 1'b0 || bBusyVec[9] !== 1'b0) begin
            errors++; $display("[TB] FAIL sb_cleared got %b %b want 0 0", aBusyVec[9], bBusyVec[9]); end
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1111; rsv_en = 1'b1; rsv_addr = 4'd9;
        tick();
        setIdle();
        #1;
        checks++; if (aBusyVec[9] !== 1'b1 || aBusy1 !== 1'b1) begin
            errors++; $display("[TB] FAIL sb_set_wins got %b %b want 1 1", aBusyVec[9], aBusy1); end
    endtask

    function automatic logic [15:0] expData(bit byp, bit zr, logic [3:0] a, logic [15:0] stored);
        if (zr && a == 4'd0) return 16'h0;
        if (byp && wr_en && !(zr && wr_addr == 4'd0) && wr_addr == a) return wr_data;
        return stored;
    endfunction

    function automatic logic expBusy(bit byp, bit zr, logic [3:0] a, logic stored);
        if (zr && a == 4'd0) return 1'b0;
        if (byp && wr_en && !(zr && wr_addr == 4'd0) && wr_addr == a) return 1'b0;
        return stored;
    endfunction

    function automatic logic [3:0] pickAddr();
        if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        logic [15:0] e1, e2;
        logic        b1, b2;
        rst = 1'b1; setIdle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin mReg[i] = '0; zReg[i] = '0; end
        mBusy = '0; zBusy = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = pickAddr(); wr_data = 16'($urandom);
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = pickAddr();
            rd_addr1 = pickAddr();
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : pickAddr();
            #1;
            e1 = expData(1, 0, rd_addr1, mReg[rd_addr1]); e2 = expData(1, 0, rd_addr2, mReg[rd_addr2]);
            b1 = expBusy(1, 0, rd_addr1, mBusy[rd_addr1]); b2 = expBusy(1, 0, rd_addr2, mBusy[rd_addr2]);
            checks++; if ({aData1, aData2, aBusy1, aBusy2, aBusyVec} !== {e1, e2, b1, b2, mBusy}) begin
                errors++; $display("[TB] FAIL rand_A cyc %0d got %h %h %b %b %h want %h %h %b %b %h",
                    cyc, aData1, aData2, aBusy1, aBusy2, aBusyVec, e1, e2, b1, b2, mBusy); end
            e1 = expData(0, 0, rd_addr1, mReg[rd_addr1]); e2 = expData(0, 0, rd_addr2, mReg[rd_addr2]);
            b1 = expBusy(0, 0, rd_addr1, mBusy[rd_addr1]); b2 = expBusy(0, 0, rd_addr2, mBusy[rd_addr2]);
            checks++; if ({bData1, bData2, bBusy1, bBusy2, bBusyVec} !== {e1, e2, b1, b2, mBusy}) begin
                errors++; $display("[TB] FAIL rand_B cyc %0d got %h %h %b %b %h want %h %h %b %b %h",
                    cyc, bData1, bData2, bBusy1, bBusy2, bBusyVec, e1, e2, b1, b2, mBusy); end
            e1 = expData(1, 1, rd_addr1, zReg[rd_addr1]); e2 = expData(1, 1, rd_addr2, zReg[rd_addr2]);
            b1 = expBusy(1, 1, rd_addr1, zBusy[rd_addr1]); b2 = expBusy(1, 1, rd_addr2, zBusy[rd_addr2]);
            checks++; if ({zData1, zData2, zBusy1, zBusy2, zBusyVec} !== {e1, e2, b1, b2, zBusy}) begin
                errors++; $display("[TB] FAIL rand_Z cyc %0d got %h %h %b %b %h want %h %h %b %b %h",
                    cyc, zData1, zData2, zBusy1, zBusy2, zBusyVec, e1, e2, b1, b2, zBusy); end
            if (wr_en) begin
                mReg[wr_addr] = wr_data; mBusy[wr_addr] = 1'b0; zBusy[wr_addr] = 1'b0;
                if (wr_addr != 4'd0) zReg[wr_addr] = wr_data;
            end
            if (rsv_en) begin
                mBusy[rsv_addr] = 1'b1;
                if (rsv_addr != 4'd0) zBusy[rsv_addr] = 1'b1;
            end
            tick();
        end
        setIdle();
    endtask

    initial begin
        setIdle(); rst = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
